// File: rtl/q2a03_pkg.sv
// ---------------------------------------------------------------------------
// q2a03_pkg
// Types and constants shared by the Q2A03 bus blocks (CPU core, sprite DMA).
//   byte_t / word_t  : data byte and bus address types used by the CPU core
//   dma_state_t      : sprite DMA sequencer states
//   *_DEFAULT        : default register-port addresses and transfer length
// ---------------------------------------------------------------------------
package q2a03_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    localparam word_t       DMA_PORT_DEFAULT = 16'h4014;
    localparam word_t       OAM_PORT_DEFAULT = 16'h2004;
    localparam int unsigned XFER_LEN_DEFAULT = 32'd256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        HALT  = 3'd2,
        ALIGN = 3'd3,
        READ  = 3'd4,
        WRITE = 3'd5
    } dma_state_t;

    // Source address of byte 'index' inside page $NN00.
    function automatic word_t page_addr(input byte_t page, input byte_t index);
        return {page, index};
    endfunction

    // True when the CPU cycle is a write to the given register port.
    function automatic logic is_port_write(input word_t addr, input logic rdwr,
                                           input word_t port);
        return (rdwr == 1'b0) && (addr == port);
    endfunction

endpackage

// File: rtl/q2a03_oam_dma.sv
// ---------------------------------------------------------------------------
// q2a03_oam_dma
// Sprite DMA engine on the Q2A03 CPU bus. A CPU write of page number NN to
// DMA_PORT halts the CPU (cpu_ready=0), then the engine owns the bus and
// copies XFER_LEN bytes from $NN00.. to OAM_PORT, one read/write pair per
// two CPU cycles, reads always on get (parity 0) cycles.
//
// Ports
//   G_clock      in   system clock
//   G_reset      in   synchronous active-high reset (wins over cpu_tick)
//   cpu_tick     in   one-clock pulse at the end of each CPU cycle
//   cpu_addr     in   CPU address of the cycle that is ending
//   cpu_wr_data  in   CPU write data
//   cpu_rdwr     in   CPU direction, 1 = read, 0 = write
//   bus_rd_data  in   read data from the muxed bus
//   cpu_ready    out  CPU ready input, 0 = halt
//   dma_active   out  DMA owns the bus this CPU cycle
//   dma_addr     out  DMA bus address
//   dma_wr_data  out  DMA write data
//   dma_rdwr     out  DMA direction, 1 = read, 0 = write
// All outputs are registered and change only on cpu_tick (or reset).
// ---------------------------------------------------------------------------
module q2a03_oam_dma
    import q2a03_pkg::*;
#(
    parameter word_t       DMA_PORT = DMA_PORT_DEFAULT,
    parameter word_t       OAM_PORT = OAM_PORT_DEFAULT,
    parameter int unsigned XFER_LEN = XFER_LEN_DEFAULT
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        cpu_tick,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rdwr,
    input  logic [7:0]  bus_rd_data,
    output logic        cpu_ready,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wr_data,
    output logic        dma_rdwr
);

    localparam byte_t LAST_INDEX = byte_t'(XFER_LEN - 32'd1);

    dma_state_t state_r,  state_s;
    byte_t      page_r,   page_s;
    byte_t      index_r,  index_s;
    logic       parity_r;

    logic       cpu_ready_r,   cpu_ready_s;
    logic       dma_active_r,  dma_active_s;
    word_t      dma_addr_r,    dma_addr_s;
    byte_t      dma_wr_data_r, dma_wr_data_s;
    logic       dma_rdwr_r,    dma_rdwr_s;

    logic       trigger_s;
    byte_t      index_inc_s;

    assign trigger_s   = is_port_write(cpu_addr, cpu_rdwr, DMA_PORT) && !dma_active_r;
    assign index_inc_s = index_r + 8'd1;

    // Next-state and next-output decode; everything holds unless a state moves it.
    always_comb begin
        state_s       = state_r;
        page_s        = page_r;
        index_s       = index_r;
        cpu_ready_s   = cpu_ready_r;
        dma_active_s  = dma_active_r;
        dma_addr_s    = dma_addr_r;
        dma_wr_data_s = dma_wr_data_r;
        dma_rdwr_s    = dma_rdwr_r;

        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    page_s      = cpu_wr_data;
                    index_s     = 8'd0;
                    cpu_ready_s = 1'b0;
                    state_s     = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end

            // The CPU only honours RDY on read cycles, so keep waiting
            // through its write cycles (e.g. a JSR push sequence).
            WAIT: begin
                if (cpu_rdwr) begin
                    dma_active_s = 1'b1;
                    dma_rdwr_s   = 1'b1;
                    state_s      = HALT;
                end else begin
                    state_s = WAIT;
                end
            end

            // parity_r is the parity of the cycle now ending; the next cycle
            // is a get cycle only when this one is a put cycle.
            HALT: begin
                dma_rdwr_s = 1'b1;
                if (parity_r == 1'b1) begin
                    dma_addr_s = page_addr(page_r, index_r);
                    state_s    = READ;
                end else begin
                    state_s = ALIGN;
                end
            end

            ALIGN: begin
                dma_rdwr_s = 1'b1;
                dma_addr_s = page_addr(page_r, index_r);
                state_s    = READ;
            end

            READ: begin
                dma_wr_data_s = bus_rd_data;
                dma_addr_s    = OAM_PORT;
                dma_rdwr_s    = 1'b0;
                state_s       = WRITE;
            end

            // The index only wraps after the last write, so the source
            // address never leaves the page.
            WRITE: begin
                index_s    = index_inc_s;
                dma_rdwr_s = 1'b1;
                if (index_r == LAST_INDEX) begin
                    dma_active_s = 1'b0;
                    cpu_ready_s  = 1'b1;
                    state_s      = IDLE;
                end else begin
                    dma_addr_s = page_addr(page_r, index_inc_s);
                    state_s    = READ;
                end
            end

            default: begin
                dma_active_s = 1'b0;
                cpu_ready_s  = 1'b1;
                dma_rdwr_s   = 1'b1;
                state_s      = IDLE;
            end
        endcase
    end

    // State, counter, parity and output registers; advance only on cpu_tick.
    always_ff @(posedge G_clock) begin
        if (G_reset) begin
            state_r       <= IDLE;
            page_r        <= 8'd0;
            index_r       <= 8'd0;
            parity_r      <= 1'b0;
            cpu_ready_r   <= 1'b1;
            dma_active_r  <= 1'b0;
            dma_addr_r    <= 16'd0;
            dma_wr_data_r <= 8'd0;
            dma_rdwr_r    <= 1'b1;
        end else if (cpu_tick) begin
            state_r       <= state_s;
            page_r        <= page_s;
            index_r       <= index_s;
            parity_r      <= ~parity_r;
            cpu_ready_r   <= cpu_ready_s;
            dma_active_r  <= dma_active_s;
            dma_addr_r    <= dma_addr_s;
            dma_wr_data_r <= dma_wr_data_s;
            dma_rdwr_r    <= dma_rdwr_s;
        end
    end

    assign cpu_ready   = cpu_ready_r;
    assign dma_active  = dma_active_r;
    assign dma_addr    = dma_addr_r;
    assign dma_wr_data = dma_wr_data_r;
    assign dma_rdwr    = dma_rdwr_r;

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_q2a03_oam_dma
// Bench for the sprite DMA engine. A memory array answers DMA reads; every
// DMA bus cycle is logged and compared against transfer-level expectations:
// stall length from trigger parity and CPU write count, 256 OAM writes of
// the page contents in order, reads of {page,i} on get cycles only.
// ---------------------------------------------------------------------------
module tb_q2a03_oam_dma;

    localparam logic [15:0] DMA_PORT = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_tick = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wr_data = 8'h00;
    logic        cpu_rdwr = 1'b1;
    logic [7:0]  bus_rd_data = 8'h00;
    logic        cpu_ready;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wr_data;
    logic        dma_rdwr;

    q2a03_oam_dma dut (
        .G_clock     (clk),
        .G_reset     (rst),
        .cpu_tick    (cpu_tick),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rdwr    (cpu_rdwr),
        .bus_rd_data (bus_rd_data),
        .cpu_ready   (cpu_ready),
        .dma_active  (dma_active),
        .dma_addr    (dma_addr),
        .dma_wr_data (dma_wr_data),
        .dma_rdwr    (dma_rdwr)
    );

    always #5 clk = ~clk;

    int    pass_cnt = 0;
    int    total_cnt = 0;
    string cur_tag = "init";

    logic [7:0]  mem [0:65535];
    bit          par;               // parity of the current CPU cycle
    int          act_cnt, wait_cnt;
    logic [15:0] rd_addr_q[$];
    bit          rd_par_q[$];
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rdwr;
        logic        exp_ready;
        logic        exp_active;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s/%s: actual %0h required %0h", cur_tag, name, act, exp);
    endtask

    task automatic clear_log();
        act_cnt = 0;
        wait_cnt = 0;
        rd_addr_q.delete();
        rd_par_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Record what the DMA drives during the CPU cycle that is about to end.
    task automatic observe();
        if (!cpu_ready && !dma_active) wait_cnt++;
        if (dma_active) begin
            act_cnt++;
            if (dma_rdwr) begin
                rd_addr_q.push_back(dma_addr);
                rd_par_q.push_back(par);
            end else begin
                wr_addr_q.push_back(dma_addr);
                wr_data_q.push_back(dma_wr_data);
            end
        end
    endtask

    // One CPU cycle: a few tick-free clocks (trigger-like inputs must be
    // ignored there), then the end-of-cycle tick. Entered and left at negedge.
    task automatic do_tick(input logic [15:0] a, input logic [7:0] d, input logic rw);
        int          gaps;
        logic [26:0] snap;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            snap = {cpu_ready, dma_active, dma_addr, dma_wr_data, dma_rdwr};
            cpu_addr    = DMA_PORT;
            cpu_rdwr    = 1'b0;
            cpu_wr_data = 8'($urandom);
            bus_rd_data = 8'($urandom);
            cpu_tick    = 1'b0;
            @(negedge clk);
            check("freeze", {cpu_ready, dma_active, dma_addr, dma_wr_data, dma_rdwr}, snap);
        end
        observe();
        cpu_addr    = a;
        cpu_wr_data = d;
        cpu_rdwr    = rw;
        bus_rd_data = (dma_active && dma_rdwr) ? mem[dma_addr] : 8'($urandom);
        cpu_tick    = 1'b1;
        @(negedge clk);
        cpu_tick = 1'b0;
        par = ~par;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready",   cpu_ready,   1'b1);
        check("rst_active",  dma_active,  1'b0);
        check("rst_addr",    dma_addr,    16'h0000);
        check("rst_wr_data", dma_wr_data, 8'h00);
        check("rst_rdwr",    dma_rdwr,    1'b1);
    endtask

    // Reset with a trigger-looking tick on the same clock: reset must win.
    task automatic reset_tick();
        rst         = 1'b1;
        cpu_tick    = 1'b1;
        cpu_addr    = DMA_PORT;
        cpu_rdwr    = 1'b0;
        cpu_wr_data = 8'h09;
        @(negedge clk);
        rst      = 1'b0;
        cpu_tick = 1'b0;
        cpu_rdwr = 1'b1;
        par      = 1'b0;
    endtask

    // Bring the trigger onto a cycle of parity want_par, then write page to DMA_PORT.
    task automatic trigger(input logic [7:0] pg, input bit want_par, output bit trig_par);
        if (par != want_par) do_tick(16'h8000, 8'h00, 1'b1);
        clear_log();
        trig_par = par;
        do_tick(DMA_PORT, pg, 1'b0);
        check("trig_ready",  cpu_ready,  1'b0);
        check("trig_active", dma_active, 1'b0);
    endtask

    // CPU side after the trigger: pre_w write cycles, then halted reads.
    task automatic run_to_done(input logic [7:0] pg, input int pre_w, input bit distract);
        int k;
        bit done;
        k = 0;
        done = 1'b0;
        while (!done && k < 1500) begin
            if (k < pre_w) begin
                if (k == 0 && distract) do_tick(DMA_PORT, pg ^ 8'hFF, 1'b0);
                else                    do_tick(16'h01FF - 16'(k), 8'($urandom), 1'b0);
            end else if (distract && dma_active && $urandom_range(0, 7) == 0) begin
                do_tick(DMA_PORT, ~pg, 1'b0);
            end else begin
                do_tick(16'h8000 + 16'(k), 8'h00, 1'b1);
            end
            k++;
            if (cpu_ready) done = 1'b1;
        end
        check("completed_in_budget", done, 1'b1);
    endtask

    // Transfer-level expectations.
    task automatic score(input logic [7:0] pg, input int pre_w, input bit trig_par);
        bit          halt_par, align;
        int          werr, rerr, base;
        logic [7:0]  ii;
        logic [15:0] src;
        halt_par = trig_par ^ bit'((pre_w + 2) % 2);
        align    = (halt_par == 1'b0);
        base     = 1 + int'(align);
        check("wait_cycles",   wait_cnt,          pre_w + 1);
        check("active_cycles", act_cnt,           513 + int'(align));
        check("write_count",   wr_data_q.size(),  256);
        check("read_count",    rd_addr_q.size(),  257 + int'(align));
        werr = 0;
        rerr = 0;
        for (int i = 0; i < 256; i++) begin
            ii  = 8'(i);
            src = {pg, ii};
            if (i >= wr_data_q.size()) werr++;
            else if (wr_addr_q[i] !== OAM_PORT || wr_data_q[i] !== mem[src]) werr++;
            if (base + i >= rd_addr_q.size()) rerr++;
            else if (rd_addr_q[base + i] !== src || rd_par_q[base + i] !== 1'b0) rerr++;
        end
        check("write_errors", werr, 0);
        check("read_errors",  rerr, 0);
        check("end_ready",  cpu_ready,  1'b1);
        check("end_active", dma_active, 1'b0);
    endtask

    task automatic transfer(input string tag, input logic [7:0] pg, input int pre_w,
                            input bit distract, input bit want_par);
        bit tp;
        cur_tag = tag;
        trigger(pg, want_par, tp);
        run_to_done(pg, pre_w, distract);
        score(pg, pre_w, tp);
    endtask

    initial begin
        bit          tp;
        bit          hit;
        logic [7:0]  pg;
        int          w0;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0700 + i] = 8'(i) ^ 8'h5A;

        vecs[0] = '{16'h4015, 8'h03, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h4014, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h4013, 8'h12, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h2004, 8'h55, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0014, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'hC014, 8'h02, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h4016, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h4014, 8'hFF, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        par = 1'b0;
        cur_tag = "reset";
        check_reset_outputs();

        // Non-trigger CPU accesses: the CPU is never halted.
        cur_tag = "no_trigger";
        clear_log();
        for (int i = 0; i < 8; i++) begin
            do_tick(vecs[i].addr, vecs[i].data, vecs[i].rdwr);
            check("ready",  cpu_ready,  vecs[i].exp_ready);
            check("active", dma_active, vecs[i].exp_active);
        end

        transfer("aligned",   8'h02, 0, 1'b0, 1'b1);
        transfer("misaligned", 8'h02, 0, 1'b0, 1'b0);
        transfer("jsr_push",  8'h03, 2, 1'b1, 1'($urandom_range(0, 1)));
        transfer("page7",     8'h07, 0, 1'b1, 1'($urandom_range(0, 1)));
        check("page7_first", wr_data_q.size() > 0 ? wr_data_q[0] : 8'hxx, 8'h5A);
        check("page7_second", wr_data_q.size() > 1 ? wr_data_q[1] : 8'hxx, 8'h5B);

        // Reset while the write of index 100 is on the bus.
        cur_tag = "mid_reset";
        trigger(8'h05, 1'($urandom_range(0, 1)), tp);
        hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            do_tick(16'h8000, 8'h00, 1'b1);
            if (wr_data_q.size() == 100 && dma_active && !dma_rdwr) hit = 1'b1;
        end
        check("reached_index100", hit, 1'b1);
        check("index100_addr", dma_addr, OAM_PORT);
        reset_tick();
        check_reset_outputs();
        w0 = wr_data_q.size();
        for (int k = 0; k < 20; k++) do_tick(16'h8000 + 16'(k), 8'h00, 1'b1);
        check("no_writes_after_reset", wr_data_q.size(), w0);
        check("idle_after_reset", cpu_ready, 1'b1);
        transfer("restart", 8'h05, 0, 1'b0, 1'($urandom_range(0, 1)));

        for (int r = 0; r < 4; r++) begin
            pg = 8'($urandom);
            transfer($sformatf("rand%0d", r), pg, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/q2a03_oam_dma.md
Name: q2a03_oam_dma

Overview:
- Sprite DMA engine that sits on the Q2A03 CPU bus, directly downstream of the CPU core's address, data and rdwr outputs.
- It snoops CPU writes to the DMA port. When triggered, it halts the CPU through the CPU's ready input, takes over the bus, and copies 256 bytes from page $NN00 to the OAM data port.
- A bus mux selects dma_addr/dma_wr_data/dma_rdwr over the CPU's bus outputs whenever dma_active=1.

Parameters:
- DMA_PORT, 16'h4014, CPU write address that triggers a transfer.
- OAM_PORT, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer.

Ports:
- G_clock  input  1  system clock.
- G_reset  input  1  synchronous, active-high reset.
- cpu_tick  input  1  one-clock pulse per CPU cycle, coincident with the CPU's phy2 falling-edge state latch.
- cpu_addr  input  16  CPU address output for the current CPU cycle.
- cpu_wr_data  input  8  CPU write data.
- cpu_rdwr  input  1  CPU direction: 1 = read, 0 = write.
- bus_rd_data  input  8  read data returned by the muxed bus.
- cpu_ready  output  1  drives the CPU G_ready input; 0 = halt.
- dma_active  output  1  DMA owns the bus this CPU cycle.
- dma_addr  output  16  DMA bus address.
- dma_wr_data  output  8  DMA write data.
- dma_rdwr  output  1  DMA direction.

Behaviour:
- All state updates occur only on clocks where cpu_tick=1. Outputs are registered and are valid for the whole following CPU cycle.
- Reset values: cpu_ready=1, dma_active=0, dma_addr=0, dma_wr_data=0, dma_rdwr=1, state=IDLE, page=0, index=0, parity=0. G_reset has priority over cpu_tick.
- parity toggles on every cpu_tick. 0 = get cycle, 1 = put cycle. It is never cleared except by reset.
- IDLE:
  - On a tick with dma_active=0, cpu_rdwr=0 and cpu_addr==DMA_PORT: latch page=cpu_wr_data, index=0, cpu_ready<=0, go to WAIT.
  - Writes to any other address are ignored.
- WAIT: CPU write cycles ignore RDY. On a tick where the just-completed cycle had cpu_rdwr=1, go to HALT; otherwise stay.
- HALT (dummy cycle):
  - dma_active<=1, dma_rdwr<=1.
  - If the next cycle is a get (parity will be 0), go to READ; else go to ALIGN.
- ALIGN: one idle bus cycle (dma_rdwr=1, address held), then READ.
- READ: dma_addr={page,index}, dma_rdwr=1. At the end-of-cycle tick, latch bus_rd_data into dma_wr_data and go to WRITE.
- WRITE: dma_addr=OAM_PORT, dma_rdwr=0. At the end-of-cycle tick:
  - index increments (8-bit wrap).
  - If index was XFER_LEN-1: go to IDLE with dma_active<=0 and cpu_ready<=1.
  - Else go to READ.
- Total stall measured from first halted read: 513 cycles if HALT lands so READ is on a get cycle, 514 with ALIGN.
- A DMA_PORT write while dma_active=1 or in WAIT is ignored; the page is not re-latched.
- Addresses never cross the page: index wraps at 255 only after the final write.
- Reset mid-transfer aborts immediately. Outputs return to reset values on that clock and no further OAM writes occur.
- cpu_tick absent: all state frozen.

Decomposition:
- Shared package q2a03_pkg holds:
  - dma_state_t enum {IDLE, WAIT, HALT, ALIGN, READ, WRITE}.
  - DMA_PORT/OAM_PORT defaults.
  - Byte/word typedefs shared with the CPU core.
- No sub-module: the counter and parity flop are inline. The bus mux lives in the top-level integration, not here.

Test Plan:
- Trigger at parity=1 with CPU reading next: write $02 to $4014 → cpu_ready=0 next cycle, HALT, READ $0200, then $2004 writes alternating through $02FF. Exactly 513 halted cycles, then cpu_ready=1.
- Same trigger offset by one cycle so READ would fall on a put cycle → one ALIGN cycle inserted, 514 halted cycles, and the first read is still on parity=0.
- Trigger followed by two CPU write cycles (JSR push pattern) → WAIT for 2 ticks, dma_active stays 0 until the first CPU read, then the normal sequence.
- Source memory byte i = i^8'h5A at page $07 → the 256 writes to $2004 carry 8'h5A, 8'h5B, … in index order; no other addresses are written.
- Assert G_reset during WRITE with index=100 → next clock cpu_ready=1, dma_active=0, dma_rdwr=1; no further $2004 writes. A new trigger afterwards restarts at index 0.
- CPU writes $03 to $4015 and reads $4014 → no trigger, and cpu_ready stays 1 throughout.
